hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and flush controller for the five-stage MIPS core. Each cycle it decides whether the F/D, D/E, E/M and M/W pipeline registers advance, hold, insert a bubble or take an exception flush. It tracks multiply/divide occupancy with an internal countdown, compares Tuse/Tnew for register hazards, and turns a CP0 exception/interrupt request into the single-cycle `req` that every pipeline register obeys with top priority.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start
- DIV_CYCLES, 10, busy cycles after a div/divu start

Ports:
- clk  in  1  single clock; all state on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- rs_D, rt_D  in  5  source registers of the D-stage instruction
- tuse_rs_D, tuse_rt_D  in  2  cycles until the operand is needed (0..2; 3 = not used)
- dst_E, dst_M  in  5  destination registers in E and M (0 = none)
- tnew_E, tnew_M  in  2  cycles until the E/M result is available
- md_D  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
- md_start_E  in  1  E instruction starts the MDU this cycle
- md_div_E  in  1  1 = divide, 0 = multiply (valid with md_start_E)
- eret_D  in  1  D instruction is eret
- exc_req  in  1  CP0 exception/interrupt request at M
- en_PC, en_FD  out  1  PC and F/D enable (0 = hold)
- nc_FD  out  1  clear F/D payload while still loading PC
- clr_DE  out  1  insert bubble into D/E
- req  out  1  exception flush to all pipeline registers
- md_busy  out  1  MDU occupied
- stall  out  1  D-stage stall indicator

## Operation
- Register hazard, rs (rt identical): `stall_rs = (rs_D != 0) && (tuse_rs_D != 3) && ((rs_D == dst_E && tnew_E > tuse_rs_D) || (rs_D == dst_M && tnew_M > tuse_rs_D))`.
- MDU hazard: `stall_md = md_D && (md_busy || md_start_E)`.
- `stall = stall_rs | stall_rt | stall_md`, but forced to 0 when req = 1.
- Outputs: en_PC = en_FD = !stall; clr_DE = stall.
- nc_FD = eret_D && !stall. The slot after eret is squashed; the PC still loads.
- req = exc_req. req overrides stall, nc_FD and clr_DE. With req = 1: en_PC = 1, en_FD = 1, nc_FD = 0, clr_DE = 0.
- MDU counter `cnt` (4 bits), two states:
  - IDLE (cnt = 0): on md_start_E && !req, load cnt = MULT_CYCLES or DIV_CYCLES and go to BUSY.
  - BUSY: decrement each cycle; return to IDLE when cnt reaches 0.
  - md_busy = (cnt != 0).
  - md_start_E while BUSY cannot occur (stall_md prevents it) and is ignored.
  - req in BUSY does not abort: the MDU result is architecturally committed.
- Reset values (all inputs 0): cnt = 0, md_busy = 0, stall = 0, en_PC = 1, en_FD = 1, nc_FD = 0, clr_DE = 0, req = 0.

## Timing
- Control outputs are combinational from inputs and `cnt`; no added latency.
- The counter updates on posedge clk. After the start edge, md_busy is high for exactly N cycles: 5 for MULT_CYCLES, 10 for DIV_CYCLES.
- A D-stage md instruction behind a mult issued in E stalls for 1 + 5 = 6 cycles.
- reset asserted mid-count forces cnt = 0 asynchronously; md_busy falls without waiting for a clock edge.
- exc_req in the same cycle as md_start_E: the counter is not loaded, because the E instruction is flushed.
- A zero parameter is illegal. The range is 1..15.

## Configuration
- `HAZARD_MDU_STALL_EN` defined: MDU counter and stall_md are compiled in.
- Undefined: no counter, md_busy tied 0, stall_md = 0, and md_D, md_start_E and md_div_E are ignored. Use this when the MDU handshakes its own busy signal.

## Structure
- Shared package `hazard_pkg` holds:
  - TUSE_NONE = 2'd3
  - the Tnew/Tuse encodings
  - default MULT_CYCLES and DIV_CYCLES
  - the counter width constant
- One sub-module, `md_busy_tracker`, contains the counter and md_busy and is compiled only under HAZARD_MDU_STALL_EN.
- Hazard comparison and priority logic stay in the top level.

## Test plan
- Load-use: rs_D = 8, tuse_rs_D = 0, dst_E = 8, tnew_E = 2 -> stall = 1, en_FD = 0, clr_DE = 1. Same with rs_D = 0 -> stall = 0.
- Mult occupancy: md_start_E = 1, md_div_E = 0 for one cycle, then md_D = 1 held -> md_busy high for 5 cycles and stall high for 6 cycles total.
- Div mid-count reset: div start, reset asserted 3 cycles later without a clock edge -> md_busy = 0 immediately, outputs at reset values.
- Exception priority: exc_req = 1 during a load-use stall -> req = 1, stall = 0, en_PC = 1, clr_DE = 0.
- Exception with MDU start: exc_req = 1 and md_start_E = 1 in the same cycle -> md_busy stays 0.
- eret: eret_D = 1, no hazard -> nc_FD = 1, en_PC = 1. eret_D = 1 with a stall -> nc_FD = 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings, defaults and the register-hazard rule for hazard_ctrl.
// Pure declarations: no logic, no latency, no flow control.
package hazard_pkg;

  localparam int CNT_W           = 4;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Tuse: cycles until a D-stage operand is consumed; TUSE_NONE = operand unused.
  typedef enum logic [1:0] {
    TUSE_0    = 2'd0,
    TUSE_1    = 2'd1,
    TUSE_2    = 2'd2,
    TUSE_NONE = 2'd3
  } tuse_e;

  // Tnew: cycles until an in-flight result can be forwarded.
  typedef enum logic [1:0] {
    TNEW_0 = 2'd0,
    TNEW_1 = 2'd1,
    TNEW_2 = 2'd2
  } tnew_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // A source stalls when a producer in E or M will not have its value ready in time.
  function automatic logic reg_hazard(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] dst_e,
    input logic [1:0] tnew_e,
    input logic [4:0] dst_m,
    input logic [1:0] tnew_m
  );
    return (src != 5'd0) && (tuse != TUSE_NONE) &&
           (((src == dst_e) && (tnew_e > tuse)) ||
            ((src == dst_m) && (tnew_m > tuse)));
  endfunction

endpackage

// File: rtl/md_busy_tracker.sv
// MDU occupancy countdown; exists only when HAZARD_MDU_STALL_EN is defined.
// md_busy is registered state, high for exactly N cycles after an accepted start; no backpressure.
`ifdef HAZARD_MDU_STALL_EN
module md_busy_tracker
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_md_start,
  input  logic i_md_div,
  input  logic i_req,
  output logic o_md_busy
);

  md_state_e        r_state;
  md_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A flushed start never loads; a flush while busy does not abort the committed op.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      MD_IDLE: begin
        if (i_md_start && !i_req) begin
          w_cnt_nxt   = i_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          w_state_nxt = MD_BUSY;
        end
      end
      MD_BUSY: begin
        if (r_cnt > CNT_W'(1)) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_cnt_nxt   = '0;
          w_state_nxt = MD_IDLE;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = MD_IDLE;
      end
    endcase
  end

  assign o_md_busy = (r_cnt != '0);

endmodule
`endif

// File: rtl/hazard_ctrl.sv
// Pipeline stall/bubble/flush control; MDU stall compiled in with HAZARD_MDU_STALL_EN.
// All outputs combinational from inputs and the MDU counter (zero latency); it is the source of backpressure, never subject to it.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [1:0] tuse_rs_D,
  input  logic [1:0] tuse_rt_D,
  input  logic [4:0] dst_E,
  input  logic [4:0] dst_M,
  input  logic [1:0] tnew_E,
  input  logic [1:0] tnew_M,
  input  logic       md_D,
  input  logic       md_start_E,
  input  logic       md_div_E,
  input  logic       eret_D,
  input  logic       exc_req,
  output logic       en_PC,
  output logic       en_FD,
  output logic       nc_FD,
  output logic       clr_DE,
  output logic       req,
  output logic       md_busy,
  output logic       stall
);

  logic w_stall_rs;
  logic w_stall_rt;
  logic w_stall_md;
  logic w_stall;

  assign w_stall_rs = reg_hazard(rs_D, tuse_rs_D, dst_E, tnew_E, dst_M, tnew_M);
  assign w_stall_rt = reg_hazard(rt_D, tuse_rt_D, dst_E, tnew_E, dst_M, tnew_M);

`ifdef HAZARD_MDU_STALL_EN
  md_busy_tracker #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_busy_tracker (
    .clk       (clk),
    .reset     (reset),
    .i_md_start(md_start_E),
    .i_md_div  (md_div_E),
    .i_req     (exc_req),
    .o_md_busy (md_busy)
  );

  // A start in E occupies the MDU from this cycle on, before the counter loads.
  assign w_stall_md = md_D && (md_busy || md_start_E);
`else
  logic w_unused_md;
  assign w_unused_md = ^{clk, reset, md_D, md_start_E, md_div_E,
                         CNT_W'(MULT_CYCLES), CNT_W'(DIV_CYCLES)};
  assign md_busy     = 1'b0;
  assign w_stall_md  = 1'b0;
`endif

  // The exception flush wins over every stall and squash.
  assign req     = exc_req;
  assign w_stall = (w_stall_rs || w_stall_rt || w_stall_md) && !exc_req;
  assign stall   = w_stall;
  assign en_PC   = !w_stall;
  assign en_FD   = !w_stall;
  assign clr_DE  = w_stall;
  assign nc_FD   = eret_D && !w_stall && !exc_req;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomised + directed scoreboard bench for hazard_ctrl.
module tb_hazard_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;
`ifdef HAZARD_MDU_STALL_EN
  localparam bit MDU_EN = 1'b1;
`else
  localparam bit MDU_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] rs_D = '0, rt_D = '0, dst_E = '0, dst_M = '0;
  logic [1:0] tuse_rs_D = '0, tuse_rt_D = '0, tnew_E = '0, tnew_M = '0;
  logic       md_D = 1'b0, md_start_E = 1'b0, md_div_E = 1'b0;
  logic       eret_D = 1'b0, exc_req = 1'b0;
  logic       en_PC, en_FD, nc_FD, clr_DE, req, md_busy, stall;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .MULT_CYCLES(MULT_N),
    .DIV_CYCLES (DIV_N)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rs_D      (rs_D),
    .rt_D      (rt_D),
    .tuse_rs_D (tuse_rs_D),
    .tuse_rt_D (tuse_rt_D),
    .dst_E     (dst_E),
    .dst_M     (dst_M),
    .tnew_E    (tnew_E),
    .tnew_M    (tnew_M),
    .md_D      (md_D),
    .md_start_E(md_start_E),
    .md_div_E  (md_div_E),
    .eret_D    (eret_D),
    .exc_req   (exc_req),
    .en_PC     (en_PC),
    .en_FD     (en_FD),
    .nc_FD     (nc_FD),
    .clr_DE    (clr_DE),
    .req       (req),
    .md_busy   (md_busy),
    .stall     (stall)
  );

  typedef struct packed {
    logic       rst;
    logic [4:0] rs, rt, de, dm;
    logic [1:0] urs, urt, te, tm;
    logic       mdd, start, div, eret, exc;
  } stim_t;

  typedef struct {
    int   n;
    logic en_pc, en_fd, nc_fd, clr_de, req, md_busy, stall;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_until = -1;  // last cycle index in which the MDU is occupied

  function automatic bit src_waits(int src, int tuse, int de, int te, int dm, int tm);
    if (src == 0 || tuse == 3) return 1'b0;
    return (src == de && te > tuse) || (src == dm && tm > tuse);
  endfunction

  task automatic apply(input stim_t s);
    exp_t e;
    bit   busy, hz;
    @(posedge clk);
    #1;
    reset = s.rst; rs_D = s.rs; rt_D = s.rt; dst_E = s.de; dst_M = s.dm;
    tuse_rs_D = s.urs; tuse_rt_D = s.urt; tnew_E = s.te; tnew_M = s.tm;
    md_D = s.mdd; md_start_E = s.start; md_div_E = s.div;
    eret_D = s.eret; exc_req = s.exc;
    if (s.rst) busy_until = -1;
    busy = MDU_EN && (cyc <= busy_until);
    hz = src_waits(int'(s.rs), int'(s.urs), int'(s.de), int'(s.te), int'(s.dm), int'(s.tm)) ||
         src_waits(int'(s.rt), int'(s.urt), int'(s.de), int'(s.te), int'(s.dm), int'(s.tm)) ||
         (MDU_EN && s.mdd && (busy || s.start));
    e.n       = cyc;
    e.req     = s.exc;
    e.stall   = hz && !s.exc;
    e.en_pc   = !e.stall;
    e.en_fd   = !e.stall;
    e.clr_de  = e.stall;
    e.nc_fd   = s.eret && !e.stall && !s.exc;
    e.md_busy = busy;
    exp_q.push_back(e);
    if (!s.rst && MDU_EN && s.start && !s.exc && !busy)
      busy_until = cyc + (s.div ? DIV_N : MULT_N);
    cyc++;
  endtask

  task automatic chk(input string nm, input int n, input logic act, input logic want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%b want=%b", nm, n, act, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("en_PC",   e.n, en_PC,   e.en_pc);
        chk("en_FD",   e.n, en_FD,   e.en_fd);
        chk("nc_FD",   e.n, nc_FD,   e.nc_fd);
        chk("clr_DE",  e.n, clr_DE,  e.clr_de);
        chk("req",     e.n, req,     e.req);
        chk("md_busy", e.n, md_busy, e.md_busy);
        chk("stall",   e.n, stall,   e.stall);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    stim_t s;
    s = '0; s.rst = 1'b1;
    apply(s);
    apply(s);
    // load-use on rs, then the same with r0
    s = '0; s.rs = 5'd8; s.urs = 2'd0; s.de = 5'd8; s.te = 2'd2;
    apply(s);
    s.rs = 5'd0;
    apply(s);
    // rt hazard via M
    s = '0; s.rt = 5'd9; s.urt = 2'd1; s.dm = 5'd9; s.tm = 2'd2;
    apply(s);
    // mult with an md instruction waiting in D
    s = '0; s.start = 1'b1; s.mdd = 1'b1;
    apply(s);
    s = '0; s.mdd = 1'b1;
    repeat (8) apply(s);
    // div, then asynchronous reset mid-count
    s = '0; s.start = 1'b1; s.div = 1'b1;
    apply(s);
    s = '0;
    repeat (3) apply(s);
    s.rst = 1'b1;
    apply(s);
    s.rst = 1'b0;
    apply(s);
    // exception during a load-use stall
    s = '0; s.rs = 5'd8; s.de = 5'd8; s.te = 2'd2; s.exc = 1'b1; s.eret = 1'b1;
    apply(s);
    // exception together with an MDU start
    s = '0; s.start = 1'b1; s.mdd = 1'b1; s.exc = 1'b1;
    apply(s);
    s = '0; s.mdd = 1'b1;
    repeat (3) apply(s);
    // eret with and without a hazard
    s = '0; s.eret = 1'b1;
    apply(s);
    s.rs = 5'd3; s.de = 5'd3; s.te = 2'd1; s.urs = 2'd0;
    apply(s);

    for (int i = 0; i < 3000; i++) begin
      s       = '0;
      s.rst   = ($urandom_range(0, 99) == 0);
      s.rs    = 5'($urandom_range(0, 3));
      s.rt    = 5'($urandom_range(0, 3));
      s.de    = 5'($urandom_range(0, 3));
      s.dm    = 5'($urandom_range(0, 3));
      s.urs   = 2'($urandom_range(0, 3));
      s.urt   = 2'($urandom_range(0, 3));
      s.te    = 2'($urandom_range(0, 3));
      s.tm    = 2'($urandom_range(0, 3));
      s.mdd   = ($urandom_range(0, 2) == 0);
      s.start = ($urandom_range(0, 4) == 0);
      s.div   = 1'($urandom_range(0, 1));
      s.eret  = ($urandom_range(0, 3) == 0);
      s.exc   = ($urandom_range(0, 11) == 0);
      apply(s);
    end

    @(posedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
